// File: rtl/ifu_fetch_thr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_fetch_thr_sched
//  Description : IFU fetch-thread scheduler. Fairness-capped round-robin
//                selection of one fetch thread per cycle, one-hot thread
//                select, a single bubble on every thread change, and a
//                per-thread privilege-mode output.
//  Revision    : 1.0  initial release
// ============================================================================
module ifu_fetch_thr_sched #(
    parameter int NTHR   = 4,
    parameter int MAXRUN = 8
) (
    input  logic            rclk,
    input  logic            reset,
    input  logic [NTHR-1:0] thr_rdy,
    input  logic            stall_f,
    input  logic [NTHR-1:0] tlu_lsu_pstate_priv,
    output logic [NTHR-1:0] thr_f,
    output logic            valid_f,
    output logic            thr_switch,
    output logic            priv_mode_f
);

    localparam int c_idx_w = (NTHR > 1) ? $clog2(NTHR) : 1;
    localparam int c_cnt_w = (MAXRUN > 1) ? $clog2(MAXRUN) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MAXRUN - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    // Index to one-hot thread vector.
    function automatic logic [NTHR-1:0] to_onehot(input logic [c_idx_w-1:0] idx);
        logic [NTHR-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin search starting at ptr; returns {found, index}.
    function automatic logic [c_idx_w:0] rr_pick(input logic [NTHR-1:0]    req,
                                                 input logic [c_idx_w-1:0] ptr);
        logic [c_idx_w:0]   res;
        logic [c_idx_w-1:0] jj;
        int                 j;
        res = '0;
        // Walk from the farthest offset to the nearest so the nearest wins.
        for (int k = NTHR - 1; k >= 0; k--) begin
            j  = (int'(ptr) + k) % NTHR;
            jj = j[c_idx_w-1:0];
            if (req[jj]) begin
                res = {1'b1, jj};
            end
        end
        return res;
    endfunction

    // Thread index after idx, wrapping at NTHR.
    function automatic logic [c_idx_w-1:0] idx_inc(input logic [c_idx_w-1:0] idx);
        int t;
        t = (int'(idx) + 1) % NTHR;
        return t[c_idx_w-1:0];
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NTHR-1:0]    r_thr_f;
    logic [NTHR-1:0]    w_thr_nxt;
    logic [c_idx_w-1:0] r_cur;
    logic [c_idx_w-1:0] w_cur_nxt;
    logic [c_idx_w-1:0] r_pend;
    logic [c_idx_w-1:0] w_pend_nxt;
    logic [c_idx_w-1:0] r_rr_ptr;
    logic [c_idx_w-1:0] w_rr_ptr_nxt;
    logic [c_cnt_w-1:0] r_run_cnt;
    logic [c_cnt_w-1:0] w_run_cnt_nxt;
    logic               r_thr_switch;

    logic [NTHR-1:0]    w_others;
    logic [c_idx_w:0]   w_pick_all;
    logic [c_idx_w:0]   w_pick_oth;
    logic               w_run_cnt_lt;

    // Candidate picks: any ready thread, or any ready thread other than the current one.
    assign w_others     = thr_rdy & ~to_onehot(r_cur);
    assign w_pick_all   = rr_pick(thr_rdy, r_rr_ptr);
    assign w_pick_oth   = rr_pick(w_others, r_rr_ptr);
    assign w_run_cnt_lt = (r_run_cnt < c_cnt_max);

    // Next-state and next-output selection; everything holds while stalled.
    always_comb begin
        w_state_nxt   = r_state;
        w_thr_nxt     = r_thr_f;
        w_cur_nxt     = r_cur;
        w_pend_nxt    = r_pend;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_run_cnt_nxt = r_run_cnt;
        if (!stall_f) begin
            unique case (r_state)
                ST_IDLE: begin
                    w_thr_nxt = '0;
                    if (w_pick_all[c_idx_w]) begin
                        w_state_nxt   = ST_RUN;
                        w_thr_nxt     = to_onehot(w_pick_all[c_idx_w-1:0]);
                        w_cur_nxt     = w_pick_all[c_idx_w-1:0];
                        w_run_cnt_nxt = '0;
                        w_rr_ptr_nxt  = idx_inc(w_pick_all[c_idx_w-1:0]);
                    end
                end
                ST_RUN: begin
                    if (thr_rdy[r_cur] && (w_run_cnt_lt || (w_others == '0))) begin
                        // Keep fetching; the count saturates when running alone.
                        if (w_run_cnt_lt) begin
                            w_run_cnt_nxt = r_run_cnt + 1'b1;
                        end
                    end else if (w_pick_oth[c_idx_w]) begin
                        w_state_nxt = ST_SWITCH;
                        w_thr_nxt   = '0;
                        w_pend_nxt  = w_pick_oth[c_idx_w-1:0];
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_thr_nxt   = '0;
                    end
                end
                ST_SWITCH: begin
                    if (thr_rdy[r_pend]) begin
                        w_state_nxt   = ST_RUN;
                        w_thr_nxt     = to_onehot(r_pend);
                        w_cur_nxt     = r_pend;
                        w_run_cnt_nxt = '0;
                        w_rr_ptr_nxt  = idx_inc(r_pend);
                    end else if (w_pick_all[c_idx_w]) begin
                        // Pending thread went away; take a fresh round-robin pick instead.
                        w_state_nxt   = ST_RUN;
                        w_thr_nxt     = to_onehot(w_pick_all[c_idx_w-1:0]);
                        w_cur_nxt     = w_pick_all[c_idx_w-1:0];
                        w_run_cnt_nxt = '0;
                        w_rr_ptr_nxt  = idx_inc(w_pick_all[c_idx_w-1:0]);
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_thr_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_thr_nxt   = '0;
                end
            endcase
        end
    end

    // Scheduler state registers.
    always_ff @(posedge rclk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_thr_f      <= '0;
            r_cur        <= '0;
            r_pend       <= '0;
            r_rr_ptr     <= '0;
            r_run_cnt    <= '0;
            r_thr_switch <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_thr_f      <= w_thr_nxt;
            r_cur        <= w_cur_nxt;
            r_pend       <= w_pend_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_run_cnt    <= w_run_cnt_nxt;
            // Pulse only on the edge that enters the bubble cycle.
            r_thr_switch <= !stall_f && (w_state_nxt == ST_SWITCH) && (r_state != ST_SWITCH);
        end
    end

    assign thr_f       = r_thr_f;
    assign valid_f     = |r_thr_f;
    assign thr_switch  = r_thr_switch & ~stall_f;
    // Strict per-index AND: a thread's privilege never leaks onto another.
    assign priv_mode_f = |(r_thr_f & tlu_lsu_pstate_priv);

    a_thr_onehot0 : assert property (@(posedge rclk) disable iff (reset) $onehot0(r_thr_f));

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch_thr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifu_fetch_thr_sched
//  Description : Self-checking bench for ifu_fetch_thr_sched with a
//                behavioural scheduling model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ifu_fetch_thr_sched;

    localparam int NTHR   = 4;
    localparam int MAXRUN = 8;

    logic       rclk = 1'b0;
    logic       reset;
    logic       stall_f;
    logic [3:0] thr_rdy;
    logic [3:0] tlu_lsu_pstate_priv;
    logic [3:0] thr_f;
    logic       valid_f;
    logic       thr_switch;
    logic       priv_mode_f;

    int total = 0;
    int bad   = 0;

    // Model: mode 0=idle, 1=fetching, 2=bubble
    int m_mode, m_cur, m_len, m_ptr, m_pend;
    bit m_sw;

    ifu_fetch_thr_sched #(.NTHR(NTHR), .MAXRUN(MAXRUN)) dut (
        .rclk               (rclk),
        .reset              (reset),
        .thr_rdy            (thr_rdy),
        .stall_f            (stall_f),
        .tlu_lsu_pstate_priv(tlu_lsu_pstate_priv),
        .thr_f              (thr_f),
        .valid_f            (valid_f),
        .thr_switch         (thr_switch),
        .priv_mode_f        (priv_mode_f)
    );

    always #5 rclk = ~rclk;

    function automatic int mpick(input logic [3:0] req, input int from);
        for (int k = 0; k < NTHR; k++) begin
            if (req[(from + k) % NTHR]) return (from + k) % NTHR;
        end
        return -1;
    endfunction

    task automatic model_grant(input int t);
        m_mode = 1;
        m_cur  = t;
        m_len  = 1;
        m_ptr  = (t + 1) % NTHR;
    endtask

    task automatic model_step(input logic rst, input logic [3:0] rdy, input logic stl);
        int t;
        logic [3:0] oth;
        if (rst) begin
            m_mode = 0; m_cur = 0; m_len = 0; m_ptr = 0; m_pend = 0; m_sw = 0;
            return;
        end
        m_sw = 0;
        if (stl) return;
        case (m_mode)
            0: begin
                t = mpick(rdy, m_ptr);
                if (t >= 0) model_grant(t);
            end
            1: begin
                oth = rdy & ~(4'b0001 << m_cur);
                if (rdy[m_cur] && (m_len < MAXRUN || oth == 4'b0)) begin
                    if (m_len < MAXRUN) m_len++;
                end else begin
                    t = mpick(oth, m_ptr);
                    if (t >= 0) begin
                        m_mode = 2; m_pend = t; m_sw = 1;
                    end else begin
                        m_mode = 0;
                    end
                end
            end
            default: begin
                if (rdy[m_pend]) model_grant(m_pend);
                else begin
                    t = mpick(rdy, m_ptr);
                    if (t >= 0) model_grant(t);
                    else m_mode = 0;
                end
            end
        endcase
    endtask

    // One clock: drive at negedge, advance the model at posedge, check just after.
    task automatic cycle(input logic rst, input logic [3:0] rdy, input logic stl,
                         input logic [3:0] prv);
        logic [3:0] e_thr;
        logic       e_sw, e_priv, e_valid;
        @(negedge rclk);
        reset = rst; thr_rdy = rdy; stall_f = stl; tlu_lsu_pstate_priv = prv;
        @(posedge rclk);
        model_step(rst, rdy, stl);
        #1;
        e_thr   = (m_mode == 1) ? (4'b0001 << m_cur) : 4'b0000;
        e_valid = (m_mode == 1);
        e_sw    = m_sw && !stl;
        e_priv  = (m_mode == 1) && prv[m_cur];
        total++;
        if (thr_f !== e_thr) begin
            bad++; $display("FAIL thr_f got=%b want=%b t=%0t", thr_f, e_thr, $time);
        end
        total++;
        if (valid_f !== e_valid) begin
            bad++; $display("FAIL valid_f got=%b want=%b t=%0t", valid_f, e_valid, $time);
        end
        total++;
        if (thr_switch !== e_sw) begin
            bad++; $display("FAIL thr_switch got=%b want=%b t=%0t", thr_switch, e_sw, $time);
        end
        total++;
        if (priv_mode_f !== e_priv) begin
            bad++; $display("FAIL priv_mode_f got=%b want=%b t=%0t", priv_mode_f, e_priv, $time);
        end
    endtask

    task automatic test_reset();
        cycle(1'b1, 4'hF, 1'b1, 4'hF);
        cycle(1'b1, 4'hF, 1'b1, 4'hF);
        total++;
        if (thr_f !== 4'b0000 || valid_f !== 1'b0 || priv_mode_f !== 1'b0) begin
            bad++; $display("FAIL reset_outputs got=%b/%b/%b want=0000/0/0", thr_f, valid_f, priv_mode_f);
        end
    endtask

    task automatic test_single();
        cycle(1'b1, 4'h0, 1'b0, 4'h0);
        cycle(1'b0, 4'b0100, 1'b0, 4'h0);
        total++;
        if (thr_f !== 4'b0100) begin
            bad++; $display("FAIL single_first got=%b want=0100", thr_f);
        end
        for (int i = 0; i < 20; i++) cycle(1'b0, 4'b0100, 1'b0, 4'h0);
        total++;
        if (thr_f !== 4'b0100) begin
            bad++; $display("FAIL single_hold got=%b want=0100", thr_f);
        end
    endtask

    task automatic test_two_thread();
        int run0;
        run0 = 0;
        cycle(1'b1, 4'h0, 1'b0, 4'h0);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 4'b0011, 1'b0, 4'h0);
            if (i < 9 && thr_f === 4'b0001) run0++;
        end
        total++;
        if (run0 != MAXRUN) begin
            bad++; $display("FAIL two_thread_run got=%0d want=%0d", run0, MAXRUN);
        end
    endtask

    task automatic test_priv_sweep();
        for (int t = 0; t < NTHR; t++) begin
            cycle(1'b1, 4'h0, 1'b0, 4'h0);
            cycle(1'b0, 4'b0001 << t, 1'b0, 4'h0);
            for (int p = 0; p < 16; p++) cycle(1'b0, 4'b0001 << t, 1'b0, 4'(p));
        end
        cycle(1'b1, 4'h0, 1'b0, 4'h0);
        cycle(1'b0, 4'b0001, 1'b0, 4'b1110);
        total++;
        if (priv_mode_f !== 1'b0) begin
            bad++; $display("FAIL priv_other got=%b want=0", priv_mode_f);
        end
        cycle(1'b0, 4'b0001, 1'b0, 4'b0001);
        total++;
        if (priv_mode_f !== 1'b1) begin
            bad++; $display("FAIL priv_own got=%b want=1", priv_mode_f);
        end
    endtask

    task automatic test_stall();
        cycle(1'b1, 4'h0, 1'b0, 4'h0);
        for (int i = 0; i < 20 && !(m_mode == 1 && m_len == 7); i++)
            cycle(1'b0, 4'b0011, 1'b0, 4'h0);
        total++;
        if (!(m_mode == 1 && m_len == 7)) begin
            bad++; $display("FAIL stall_setup got=%0d want=7", m_len);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 4'b0011, 1'b1, 4'h0);
            total++;
            if (thr_f !== 4'b0001 || thr_switch !== 1'b0) begin
                bad++; $display("FAIL stall_hold got=%b/%b want=0001/0", thr_f, thr_switch);
            end
        end
        cycle(1'b0, 4'b0011, 1'b0, 4'h0);
        total++;
        if (thr_f !== 4'b0001) begin
            bad++; $display("FAIL stall_release got=%b want=0001", thr_f);
        end
        cycle(1'b0, 4'b0011, 1'b0, 4'h0);
        total++;
        if (thr_switch !== 1'b1 || thr_f !== 4'b0000) begin
            bad++; $display("FAIL stall_forced_switch got=%b/%b want=1/0000", thr_switch, thr_f);
        end
    endtask

    task automatic test_switch_pending();
        cycle(1'b1, 4'h0, 1'b0, 4'h0);
        for (int i = 0; i < 40 && m_mode != 2; i++) cycle(1'b0, 4'b0110, 1'b0, 4'h0);
        total++;
        if (m_mode != 2 || m_pend != 2) begin
            bad++; $display("FAIL pend_setup got=%0d/%0d want=2/2", m_mode, m_pend);
        end
        cycle(1'b0, 4'b1000, 1'b0, 4'h0);
        total++;
        if (thr_f !== 4'b1000) begin
            bad++; $display("FAIL pend_dropped got=%b want=1000", thr_f);
        end
        for (int i = 0; i < 40 && m_mode != 2; i++) cycle(1'b0, 4'b1001, 1'b0, 4'h0);
        cycle(1'b0, 4'b0000, 1'b0, 4'h0);
        total++;
        if (thr_f !== 4'b0000 || valid_f !== 1'b0) begin
            bad++; $display("FAIL all_dropped got=%b/%b want=0000/0", thr_f, valid_f);
        end
    endtask

    task automatic test_random();
        cycle(1'b1, 4'h0, 1'b0, 4'h0);
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 199) == 0), 4'($urandom), ($urandom_range(0, 9) < 2),
                  4'($urandom));
        end
    endtask

    initial begin
        reset = 1'b1; stall_f = 1'b0; thr_rdy = 4'h0; tlu_lsu_pstate_priv = 4'h0;
        test_reset();
        test_single();
        test_two_thread();
        test_priv_sweep();
        test_stall();
        test_switch_pending();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
